mult_out_packer: RTL and testbench

- Downstream consumer of the 1-bit registered multiplier stage: samples its product output one bit per cycle and packs the bits LSB-first into WORD_W-bit words.
- Each word carries its valid-bit length and a popcount, and drains through a 2-entry output queue with a valid/ready handshake.
- Keeps a saturating running count of accepted 1 bits for test observation.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_out_packer_if.sv | 31 +++
 rtl/mult_out_packer_fifo.sv | 49 ++++
 rtl/mult_out_packer.sv | 99 +++++++++
 tb/tb_mult_out_packer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier output packer.
package mult_pkg;

  localparam int unsigned WORD_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned LEN_W_DEF  = $clog2(WORD_W_DEF + 1);

  typedef struct packed {
    logic [WORD_W_DEF-1:0] word;
    logic [LEN_W_DEF-1:0]  len;
    logic [LEN_W_DEF-1:0]  ones;
  } pack_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLUSH_WAIT
  } pack_state_t;

endpackage

// File: rtl/mult_out_packer_if.sv
// Bit-input / packed-word-output bus of the multiplier output packer.
interface mult_out_packer_if
  import mult_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);
  localparam int unsigned LEN_W = $clog2(WORD_W + 1);

  logic              in_valid;
  logic              in_bit;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic [LEN_W-1:0]  out_len;
  logic [LEN_W-1:0]  out_ones;
  logic [CNT_W-1:0]  total_ones;
  logic              total_sat;

  modport master (
    output in_valid, in_bit, flush, out_ready,
    input  in_ready, out_valid, out_word, out_len, out_ones, total_ones, total_sat
  );

  modport slave (
    input  in_valid, in_bit, flush, out_ready,
    output in_ready, out_valid, out_word, out_len, out_ones, total_ones, total_sat
  );
endinterface

// File: rtl/mult_out_packer_fifo.sv
// Two-entry registered FIFO; entry 0 is the head and feeds the outputs directly.
module pack_fifo2
  import mult_pkg::*;
#(
  parameter type T = pack_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     head,
  output logic valid,
  output logic full,
  output logic empty
);
  T           e1;
  logic [1:0] cnt, cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (push && !pop)      cnt_next = cnt + 2'd1;
    else if (!push && pop) cnt_next = cnt - 2'd1;
  end

  // e1 is kept zero whenever it is not occupied, so shifting it into the head clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      e1    <= '0;
      cnt   <= 2'd0;
      valid <= 1'b0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (pop) begin
        head <= (push && cnt == 2'd1) ? din : e1;
        e1   <= (push && cnt == 2'd2) ? din : '0;
      end else if (push) begin
        if (cnt == 2'd0) head <= din;
        else             e1   <= din;
      end
      cnt   <= cnt_next;
      valid <= (cnt_next != 2'd0);
      full  <= (cnt_next == 2'd2);
      empty <= (cnt_next == 2'd0);
    end
  end
endmodule

// File: rtl/mult_out_packer.sv
// Packs the multiplier's serial product bits LSB-first into words with length and popcount.
module mult_out_packer
  import mult_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  mult_out_packer_if.slave bus
);
  localparam int unsigned      LEN_W   = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  ones;
  } entry_t;

  pack_state_t       state, state_next;
  logic [WORD_W-1:0] shift, shift_acc, shift_next;
  logic [LEN_W-1:0]  idx, idx_acc, idx_next;
  logic [LEN_W-1:0]  ones, ones_acc, ones_next;
  logic              accept, word_done, pend, pop, slot, push, in_ready_next;
  logic              fifo_valid, fifo_full, fifo_empty;
  entry_t            push_entry, head;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_ready & ~fifo_empty;

  // Next-state and push decision; a pending flush only survives while the queue is full
  always_comb begin
    shift_acc     = shift;
    idx_acc       = idx;
    ones_acc      = ones;
    if (accept) begin
      shift_acc = shift | (WORD_W'(bus.in_bit) << idx);
      idx_acc   = idx + LEN_W'(1);
      ones_acc  = ones + LEN_W'(bus.in_bit);
    end
    word_done     = accept && (idx_acc == LEN_W'(WORD_W));
    pend          = (state == ST_FLUSH_WAIT) || bus.flush;
    slot          = !fifo_full || pop;
    push          = word_done || (pend && (idx_acc != '0) && slot);
    push_entry.word = shift_acc;
    push_entry.len  = idx_acc;
    push_entry.ones = ones_acc;
    shift_next    = push ? '0 : shift_acc;
    idx_next      = push ? '0 : idx_acc;
    ones_next     = push ? '0 : ones_acc;
    in_ready_next = !(fifo_full && !pop);
    state_next    = ST_IDLE;
    if (pend && !push && (idx_acc != '0)) state_next = ST_FLUSH_WAIT;
    else if (idx_next != '0)              state_next = ST_FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift          <= '0;
      idx            <= '0;
      ones           <= '0;
      bus.in_ready   <= 1'b1;
      bus.total_ones <= '0;
      bus.total_sat  <= 1'b0;
    end else begin
      shift        <= shift_next;
      idx          <= idx_next;
      ones         <= ones_next;
      bus.in_ready <= in_ready_next;
      if (accept && bus.in_bit && (bus.total_ones != CNT_MAX)) begin
        bus.total_ones <= bus.total_ones + CNT_W'(1);
        if (bus.total_ones == CNT_MAX - CNT_W'(1)) bus.total_sat <= 1'b1;
      end
    end
  end

  pack_fifo2 #(.T(entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .valid (fifo_valid),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_word  = head.word;
  assign bus.out_len   = head.len;
  assign bus.out_ones  = head.ones;
endmodule

// File: tb/tb_mult_out_packer.sv
// Directed bench for mult_out_packer with a queue-level reference model and a CNT_W=4 twin.
module tb_mult_out_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_out_packer_if #(.WORD_W(8), .CNT_W(16)) bus ();
  mult_out_packer_if #(.WORD_W(8), .CNT_W(4))  bus2 ();

  mult_out_packer #(.WORD_W(8), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mult_out_packer #(.WORD_W(8), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Twin sees the same bits but never backs up, so it accepts every valid bit
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_bit    = bus.in_bit;
  assign bus2.flush     = 1'b0;
  assign bus2.out_ready = 1'b1;

  int nvec = 0;
  int nmis = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words as queue entries, the partial word as a list of bits
  typedef struct {
    int word;
    int len;
    int ones;
  } ent_t;

  ent_t q[$];
  bit   cur[$];
  bit   pend_m = 0;
  bit   rdy_m = 1;
  int   total_m = 0, total2_m = 0;
  bit   sat_m = 0, sat2_m = 0;
  bit   acc_m, pop_m, push_m, full_m;
  ent_t e_m;

  function automatic ent_t pack_bits(input bit b[$]);
    ent_t e;
    e.word = 0; e.len = b.size(); e.ones = 0;
    foreach (b[i]) begin
      e.word += int'(b[i]) * (1 << i);
      e.ones += int'(b[i]);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete(); cur.delete();
      pend_m = 0; rdy_m = 1;
      total_m = 0; sat_m = 0; total2_m = 0; sat2_m = 0;
    end else begin
      acc_m  = bus.in_valid && rdy_m;
      pop_m  = (q.size() > 0) && bus.out_ready;
      full_m = (q.size() == 2) && !pop_m;
      if (bus.in_valid && bus.in_bit && total2_m < 15) total2_m++;
      if (total2_m == 15) sat2_m = 1;
      if (acc_m) begin
        cur.push_back(bus.in_bit);
        if (bus.in_bit && total_m < 65535) total_m++;
        if (total_m == 65535) sat_m = 1;
      end
      if (bus.flush) pend_m = 1;
      push_m = 0;
      if (cur.size() == 8) begin
        e_m = pack_bits(cur); push_m = 1; cur.delete(); pend_m = 0;
      end else if (pend_m) begin
        if (cur.size() == 0) pend_m = 0;
        else if (q.size() - int'(pop_m) < 2) begin
          e_m = pack_bits(cur); push_m = 1; cur.delete(); pend_m = 0;
        end
      end
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(e_m);
      rdy_m = !full_m;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(bus.in_ready), 32'(rdy_m));
      if (q.size() > 0) begin
        chk("out_word", 32'(bus.out_word), 32'(q[0].word));
        chk("out_len", 32'(bus.out_len), 32'(q[0].len));
        chk("out_ones", 32'(bus.out_ones), 32'(q[0].ones));
      end
      chk("total_ones", 32'(bus.total_ones), 32'(total_m));
      chk("total_sat", 32'(bus.total_sat), 32'(sat_m));
      chk("twin_in_ready", 32'(bus2.in_ready), 32'd1);
      chk("twin_total", 32'(bus2.total_ones), 32'(total2_m));
      chk("twin_sat", 32'(bus2.total_sat), 32'(sat2_m));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    bit rd, done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    for (int i = 0; i < 40; i++) begin
      rd = bus.in_ready;
      step();
      if (rd) begin
        done = 1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      nvec++; nmis++;
      $display("FAIL send_timeout: bit not accepted within 40 cycles at %0t", $time);
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    logic [7:0] t;
    t = w;
    for (int i = 0; i < 8; i++) send_bit(t[i]);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_en = 1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_total", 32'(bus.total_ones), 32'd0);
    chk("reset_word", 32'(bus.out_word), 32'd0);

    // 1,0,1,1,0,0,1,0 LSB-first is 0x4D
    bus.out_ready = 1'b1;
    send_word(8'h4D);
    chk("w4d_word", 32'(bus.out_word), 32'h4D);
    chk("w4d_len", 32'(bus.out_len), 32'd8);
    chk("w4d_ones", 32'(bus.out_ones), 32'd4);
    chk("w4d_total", 32'(bus.total_ones), 32'd4);
    step(); step();

    // Back-pressure: two words fill the queue, third word stalls
    bus.out_ready = 1'b0;
    send_word(8'hA5);
    send_word(8'h3C);
    send_bit(1'b0);
    bus.in_valid = 1'b1; bus.in_bit = 1'b0;
    step(); step(); step();
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head_stable", 32'(bus.out_word), 32'hA5);
    bus.out_ready = 1'b1;
    send_bit(1'b0);
    for (int i = 2; i < 8; i++) send_bit(1'b1);
    repeat (6) step();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Partial word flush, then flush with nothing held
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    pulse_flush();
    chk("fl_word", 32'(bus.out_word), 32'h07);
    chk("fl_len", 32'(bus.out_len), 32'd3);
    chk("fl_ones", 32'(bus.out_ones), 32'd3);
    pulse_flush();
    chk("fl_empty0", 32'(bus.out_valid), 32'd0);
    step();
    chk("fl_empty1", 32'(bus.out_valid), 32'd0);

    // Flush while the queue is full: held until the first pop
    bus.out_ready = 1'b0;
    send_word(8'h5A);
    send_word(8'hC3);
    send_bit(1'b1);
    pulse_flush();
    step(); step(); step();
    chk("fw_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fw_head", 32'(bus.out_word), 32'h5A);
    bus.out_ready = 1'b1;
    step();
    chk("fw_second", 32'(bus.out_word), 32'hC3);
    step();
    chk("fw_part_word", 32'(bus.out_word), 32'h01);
    chk("fw_part_len", 32'(bus.out_len), 32'd1);
    chk("fw_part_ones", 32'(bus.out_ones), 32'd1);
    repeat (3) step();

    // Reset with one queued word and a half-built word
    bus.out_ready = 1'b0;
    send_word(8'hFF);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_total", 32'(bus.total_ones), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    send_word(8'h96);
    chk("rst_fresh_word", 32'(bus.out_word), 32'h96);
    chk("rst_fresh_len", 32'(bus.out_len), 32'd8);
    chk("rst_fresh_ones", 32'(bus.out_ones), 32'd4);

    // Twin counter saturates at 15
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    chk("sat_twin_total", 32'(bus2.total_ones), 32'd15);
    chk("sat_twin_flag", 32'(bus2.total_sat), 32'd1);
    chk("sat_main_total", 32'(bus.total_ones), 32'd24);
    chk("sat_main_flag", 32'(bus.total_sat), 32'd0);
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
